// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter
//
// Shares one CNT_W-bit up-counter among N_REQ clients. Requests are served
// in round-robin order. A granted client's counter runs from 0 up to its
// target, and then that client gets a single-cycle done pulse.
//
// State table:
//   state   | meaning
//   S_IDLE  | no grant; counter held at 0; looking for a request from ptr upward
//   S_COUNT | grant active; counter climbing toward the latched target
//   S_DONE  | one-cycle completion; done pulse for the granted client
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   req    in   [N_REQ]        per-client request level
//   tgt    in   [N_REQ*CNT_W]  flattened targets; client i uses tgt[i*CNT_W +: CNT_W]
//   gnt    out  [N_REQ]        one-hot grant, zero when idle
//   done   out  [N_REQ]        one-hot single-cycle completion pulse
//   busy   out                 high whenever not idle
//   cnt_q  out  [CNT_W]        live counter value
module counter_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   tgt,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt_q
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [N_REQ-1:0]   gnt_d, done_d;
    logic               busy_d;
    logic [CNT_W-1:0]   cnt_d;

    logic               found;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   sel_nxt;
    logic [PTR_W-1:0]   cand;
    int                 j;

    // Round-robin search: first requester at or after ptr, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = PTR_W'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        if (int'(sel) == N_REQ - 1) begin
            sel_nxt = '0;
        end else begin
            sel_nxt = sel + PTR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        gnt_d   = gnt;
        done_d  = '0;
        busy_d  = busy;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d    = S_COUNT;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    tgt_d      = tgt[int'(sel)*CNT_W +: CNT_W];
                    idx_d      = sel;
                    ptr_d      = sel_nxt;
                    busy_d     = 1'b1;
                end
            end
            S_COUNT: begin
                if (!req[idx_q]) begin
                    // client withdrew: abort without a done pulse
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == tgt_q) begin
                    state_d       = S_DONE;
                    done_d[idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            gnt     <= gnt_d;
            done    <= done_d;
            busy    <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_counter_timer_arbiter.sv
module tb_counter_timer_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] tgt;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt_q;

    int n_checks = 0;
    int n_errors = 0;

    counter_timer_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .tgt   (tgt),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .cnt_q (cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},  32'(gnt),   32'h0);
        check({tag, "_done"}, 32'(done),  32'h0);
        check({tag, "_busy"}, 32'(busy),  32'h0);
        check({tag, "_cnt"},  32'(cnt_q), 32'h0);
    endtask

    logic [3:0] exp_g;

    initial begin
        rst = 1'b0;
        req = 4'b1111;
        tgt = {4'd2, 4'd2, 4'd2, 4'd2};

        // reset values while requests are pending
        step();
        step();
        check_idle("rst");
        rst = 1'b1;
        step();
        check("rst_first_gnt", 32'(gnt), 32'h1);
        check("rst_first_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check_idle("rst_abort");

        // single request, target 5 on requester 2 (ptr is now 1)
        tgt[8 +: 4] = 4'd5;
        req = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            step();
            check("single_gnt",  32'(gnt),   32'h4);
            check("single_cnt",  32'(cnt_q), (k < 6) ? 32'(k) : 32'd5);
            check("single_done", 32'(done),  (k == 6) ? 32'h4 : 32'h0);
        end
        req = 4'b0000;
        step();
        check_idle("single_end");

        // round robin from a fresh pointer, all targets 2
        rst = 1'b0;
        #1;
        step();
        rst = 1'b1;
        tgt = {4'd2, 4'd2, 4'd2, 4'd2};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                step();
                check("rr_gnt",  32'(gnt),   32'(exp_g));
                check("rr_cnt",  32'(cnt_q), (c < 2) ? 32'(c) : 32'd2);
                check("rr_done", 32'(done),  (c == 3) ? 32'(exp_g) : 32'h0);
            end
            step();
            check("rr_gap_gnt",  32'(gnt),  32'h0);
            check("rr_gap_busy", 32'(busy), 32'h0);
            if (g == 4) req = 4'b0000;
        end

        // T=0 on requester 1 (ptr is 1)
        tgt[4 +: 4] = 4'd0;
        req = 4'b0010;
        step();
        check("t0_gnt",  32'(gnt),   32'h2);
        check("t0_cnt",  32'(cnt_q), 32'h0);
        check("t0_done0", 32'(done), 32'h0);
        step();
        check("t0_done1", 32'(done), 32'h2);
        check("t0_gnt1",  32'(gnt),  32'h2);
        req = 4'b0000;
        step();
        check_idle("t0_end");

        // T=15 on requester 3, tgt changed after grant must be ignored
        tgt[12 +: 4] = 4'd15;
        req = 4'b1000;
        for (int k = 0; k < 17; k++) begin
            step();
            if (k == 0) tgt[12 +: 4] = 4'd3;
            check("t15_gnt",  32'(gnt),   32'h8);
            check("t15_cnt",  32'(cnt_q), (k <= 15) ? 32'(k) : 32'd15);
            check("t15_done", 32'(done),  (k == 16) ? 32'h8 : 32'h0);
        end
        req = 4'b0000;
        step();
        check_idle("t15_end");

        // abort: requester 1, T=10, drop req at cnt_q=3 (ptr is 0)
        tgt = {4'd10, 4'd10, 4'd10, 4'd10};
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_gnt", 32'(gnt),   32'h2);
            check("abort_cnt", 32'(cnt_q), 32'(k));
        end
        req = 4'b0000;
        step();
        check_idle("abort_after");
        req = 4'b1111;
        step();
        check("abort_next_gnt", 32'(gnt), 32'h4);

        // reset mid-count at cnt_q=6
        for (int k = 1; k <= 6; k++) begin
            step();
        end
        check("midrst_cnt_before", 32'(cnt_q), 32'd6);
        rst = 1'b0;
        #1;
        check_idle("midrst_async");
        step();
        check_idle("midrst_held");
        rst = 1'b1;
        step();
        check("midrst_first_gnt", 32'(gnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
